// File: rtl/mips_pkg.sv
// Shared types and default widths for the register-bank writeback path.
package mips_pkg;

  localparam int unsigned MIPS_WL         = 32;
  localparam int unsigned MIPS_AL         = 5;
  localparam int unsigned MIPS_STARVE_MAX = 3;

  // One queued writeback: destination register plus result word.
  typedef struct packed {
    logic [MIPS_AL-1:0] addr;
    logic [MIPS_WL-1:0] data;
  } wb_entry_t;

  // Source selected for the register-bank write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MDU  = 2'd2
  } wr_src_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small skid FIFO holding MDU results until the write port is free.
module wb_skid_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];

  // Push is refused when full, pop is ignored when empty.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Occupancy count; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-bank write port between the pipeline WB stage
// and queued MDU results, and tracks registers awaiting an MDU result.
module rf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned WL         = MIPS_WL,
  parameter int unsigned AL         = MIPS_AL,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = MIPS_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AL-1:0] wb_addr,
  input  logic [WL-1:0] wb_data,
  output logic          wb_stall,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AL-1:0] mdu_addr,
  input  logic [WL-1:0] mdu_data,
  input  logic          iss_valid,
  input  logic [AL-1:0] iss_addr,
  input  logic [AL-1:0] rs_addr,
  input  logic [AL-1:0] rt_addr,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          wr_en,
  output logic [AL-1:0] w_addr,
  output logic [WL-1:0] w_data
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned NR = 2 ** AL;

  // FIFO interface
  wb_entry_t     w_push_entry;
  wb_entry_t     w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  // Arbitration and registered write port
  wr_src_e       w_src;
  logic          w_wr_en_n;
  logic [AL-1:0] w_addr_n;
  logic [WL-1:0] w_data_n;
  logic          r_wr_en;
  logic [AL-1:0] r_w_addr;
  logic [WL-1:0] r_w_data;

  // Starvation guard
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_n;
  logic          r_wb_stall;
  logic          w_wb_stall_n;

  // Pending-write scoreboard
  logic [NR-1:0] r_busy;
  logic [NR-1:0] w_busy_n;

  assign w_push_entry = '{addr: mdu_addr, data: mdu_data};

  // Ready is held low throughout reset so the MDU cannot push into a
  // FIFO that is being cleared.
  assign mdu_ready = (w_count < CW'(DEPTH)) && !rst;
  assign w_push    = mdu_valid && mdu_ready && !w_full;

  wb_skid_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Pick the write source: a forced MDU slot beats WB, WB beats an idle MDU pop.
  always_comb begin
    w_src = SRC_NONE;
    if (r_wb_stall && !w_empty) begin
      w_src = SRC_MDU;
    end else if (wb_valid) begin
      w_src = SRC_WB;
    end else if (!w_empty) begin
      w_src = SRC_MDU;
    end
  end

  assign w_pop = (w_src == SRC_MDU);

  // Build the next write-port value; register 0 is consumed without a write.
  always_comb begin
    w_wr_en_n = 1'b0;
    w_addr_n  = r_w_addr;
    w_data_n  = r_w_data;
    unique case (w_src)
      SRC_WB: begin
        if (wb_addr != '0) begin
          w_wr_en_n = 1'b1;
          w_addr_n  = wb_addr;
          w_data_n  = wb_data;
        end
      end
      SRC_MDU: begin
        if (w_head.addr != '0) begin
          w_wr_en_n = 1'b1;
          w_addr_n  = w_head.addr;
          w_data_n  = w_head.data;
        end
      end
      default: ;
    endcase
  end

  // Register the write port for a fixed one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en  <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      r_wr_en  <= w_wr_en_n;
      r_w_addr <= w_addr_n;
      r_w_data <= w_data_n;
    end
  end

  assign wr_en  = r_wr_en;
  assign w_addr = r_w_addr;
  assign w_data = r_w_data;

  // Count cycles the FIFO head waits; stall WB once the wait limit is reached.
  always_comb begin
    if (w_pop || w_empty) begin
      w_starve_n = '0;
    end else if (r_starve == SW'(STARVE_MAX)) begin
      w_starve_n = r_starve;
    end else begin
      w_starve_n = r_starve + SW'(1);
    end
    w_wb_stall_n = (r_starve == SW'(STARVE_MAX - 1)) && !w_pop && !w_empty;
  end

  // Starvation counter and registered stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve   <= '0;
      r_wb_stall <= 1'b0;
    end else begin
      r_starve   <= w_starve_n;
      r_wb_stall <= w_wb_stall_n;
    end
  end

  assign wb_stall = r_wb_stall;

  // Scoreboard update: clear on MDU pop, then set on issue so a same-cycle
  // set of the popped address wins.
  always_comb begin
    w_busy_n = r_busy;
    if (w_pop) begin
      w_busy_n[w_head.addr] = 1'b0;
    end
    if (iss_valid && (iss_addr != '0)) begin
      w_busy_n[iss_addr] = 1'b1;
    end
    w_busy_n[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_n;
    end
  end

  assign rs_busy = r_busy[rs_addr] && (rs_addr != '0);
  assign rt_busy = r_busy[rt_addr] && (rt_addr != '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        wr_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(
    .WL         (32),
    .AL         (5),
    .DEPTH      (2),
    .STARVE_MAX (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .wr_en     (wr_en),
    .w_addr    (w_addr),
    .w_data    (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    mdu_valid = 1'b0;
    mdu_addr  = '0;
    mdu_data  = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, ".wr_en"}, 64'(wr_en), 64'd1);
    check_eq({tag, ".w_addr"}, 64'(w_addr), 64'(a));
    check_eq({tag, ".w_data"}, 64'(w_data), 64'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    rs_addr = 5'd8;
    rt_addr = 5'd0;
    idle_inputs();

    // Reset state
    tick();
    tick();
    check_eq("rst.wr_en", 64'(wr_en), 64'd0);
    check_eq("rst.w_addr", 64'(w_addr), 64'd0);
    check_eq("rst.w_data", 64'(w_data), 64'd0);
    check_eq("rst.wb_stall", 64'(wb_stall), 64'd0);
    check_eq("rst.mdu_ready", 64'(mdu_ready), 64'd0);
    check_eq("rst.rs_busy", 64'(rs_busy), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rel.mdu_ready", 64'(mdu_ready), 64'd1);

    // WB only, then WB to register 0
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    check_write("wb5", 5'd5, 32'hDEADBEEF);
    wb_addr = 5'd0; wb_data = 32'h00000111;
    tick();
    check_eq("wb0.wr_en", 64'(wr_en), 64'd0);
    idle_inputs();
    tick();
    check_eq("idle.wr_en", 64'(wr_en), 64'd0);

    // MDU idle slot with scoreboard tracking
    iss_valid = 1'b1; iss_addr = 5'd8;
    tick();
    iss_valid = 1'b0;
    rs_addr = 5'd8; rt_addr = 5'd9;
    #1;
    check_eq("iss8.rs_busy", 64'(rs_busy), 64'd1);
    check_eq("iss8.rt_busy", 64'(rt_busy), 64'd0);
    mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_data = 32'h00001234;
    tick();
    mdu_valid = 1'b0;
    check_eq("queued8.rs_busy", 64'(rs_busy), 64'd1);
    check_eq("queued8.wr_en", 64'(wr_en), 64'd0);
    tick();
    check_write("mdu8", 5'd8, 32'h00001234);
    check_eq("popped8.rs_busy", 64'(rs_busy), 64'd0);

    // MDU result to register 0 is dropped
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h00000077;
    tick();
    mdu_valid = 1'b0;
    tick();
    check_eq("mdu0.wr_en", 64'(wr_en), 64'd0);
    check_eq("mdu0.mdu_ready", 64'(mdu_ready), 64'd1);

    // Backpressure: FIFO fills behind a busy WB stream
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h00000033;
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h000000A1;
    #1;
    check_eq("bp.ready0", 64'(mdu_ready), 64'd1);
    tick();
    mdu_addr = 5'd10; mdu_data = 32'h000000A2;
    check_eq("bp.ready1", 64'(mdu_ready), 64'd1);
    tick();
    mdu_addr = 5'd11; mdu_data = 32'h000000A3;
    #1;
    check_eq("bp.full_ready", 64'(mdu_ready), 64'd0);
    check_write("bp.wb_a", 5'd3, 32'h00000033);
    tick();
    check_eq("bp.stall_early", 64'(wb_stall), 64'd0);
    check_eq("bp.held_ready", 64'(mdu_ready), 64'd0);
    tick();
    check_eq("bp.stall", 64'(wb_stall), 64'd1);
    check_write("bp.wb_b", 5'd3, 32'h00000033);
    tick();
    check_write("bp.mdu9", 5'd9, 32'h000000A1);
    check_eq("bp.stall_drop", 64'(wb_stall), 64'd0);
    check_eq("bp.ready_again", 64'(mdu_ready), 64'd1);
    tick();
    check_write("bp.wb_held", 5'd3, 32'h00000033);
    mdu_valid = 1'b0; wb_valid = 1'b0;
    tick();
    check_write("bp.mdu10", 5'd10, 32'h000000A2);
    tick();
    check_write("bp.mdu11", 5'd11, 32'h000000A3);
    tick();
    check_eq("bp.drained", 64'(wr_en), 64'd0);

    // Starvation guard with a distinct WB word each cycle
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h000000B0;
    mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'h000000C0;
    tick();
    check_write("sv.b0", 5'd4, 32'h000000B0);
    mdu_valid = 1'b0; wb_data = 32'h000000B1;
    tick();
    check_write("sv.b1", 5'd4, 32'h000000B1);
    check_eq("sv.stall1", 64'(wb_stall), 64'd0);
    wb_data = 32'h000000B2;
    tick();
    check_write("sv.b2", 5'd4, 32'h000000B2);
    check_eq("sv.stall2", 64'(wb_stall), 64'd0);
    wb_data = 32'h000000B3;
    tick();
    check_write("sv.b3", 5'd4, 32'h000000B3);
    check_eq("sv.stall3", 64'(wb_stall), 64'd1);
    wb_data = 32'h000000B4;
    tick();
    check_write("sv.c0", 5'd12, 32'h000000C0);
    check_eq("sv.stall4", 64'(wb_stall), 64'd0);
    tick();
    check_write("sv.b4", 5'd4, 32'h000000B4);
    wb_valid = 1'b0;
    tick();
    check_eq("sv.idle", 64'(wr_en), 64'd0);

    // Same-cycle set and clear of register 8: set wins
    iss_valid = 1'b1; iss_addr = 5'd8;
    tick();
    iss_valid = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_data = 32'h00005555;
    tick();
    mdu_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd8;
    tick();
    iss_valid = 1'b0;
    rs_addr = 5'd8; rt_addr = 5'd0;
    #1;
    check_eq("sc.rs_busy", 64'(rs_busy), 64'd1);
    check_eq("sc.rt_zero", 64'(rt_busy), 64'd0);
    check_write("sc.mdu8", 5'd8, 32'h00005555);

    // Asynchronous reset with FIFO full and busy bits set
    iss_valid = 1'b1; iss_addr = 5'd20;
    tick();
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h00000066;
    mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'h000000D0;
    tick();
    mdu_addr = 5'd21; mdu_data = 32'h000000D1;
    tick();
    mdu_addr = 5'd22; mdu_data = 32'h000000D2;
    rs_addr = 5'd20;
    #1;
    check_eq("ar.pre_ready", 64'(mdu_ready), 64'd0);
    check_eq("ar.pre_busy", 64'(rs_busy), 64'd1);
    check_eq("ar.pre_wr_en", 64'(wr_en), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("ar.wr_en", 64'(wr_en), 64'd0);
    check_eq("ar.mdu_ready", 64'(mdu_ready), 64'd0);
    check_eq("ar.rs_busy", 64'(rs_busy), 64'd0);
    check_eq("ar.w_addr", 64'(w_addr), 64'd0);
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("ar.rel_ready", 64'(mdu_ready), 64'd1);
    tick();
    check_eq("ar.no_stale1", 64'(wr_en), 64'd0);
    tick();
    check_eq("ar.no_stale2", 64'(wr_en), 64'd0);
    check_eq("ar.busy_after", 64'(rs_busy), 64'd0);
    check_eq("ar.stall_after", 64'(wb_stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
